// File: rtl/pattern_response_compactor.sv
// pattern_response_compactor: skips warm-up response beats, folds the rest
// into a MISR and compares the final signature against a golden value.
module pattern_response_compactor #(
  parameter int unsigned       RESP_W = 7,
  parameter int unsigned       SIG_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED   = 16'hFFFF,
  parameter int unsigned       SKIP   = 2,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic [CNT_W-1:0]  pat_count,
  input  logic [SIG_W-1:0]  golden,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  beats
);

  localparam int unsigned SKW = (SKIP > 1) ? $clog2(SKIP) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKIP = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [SKW-1:0]    skip_cnt_q, skip_cnt_d;
  logic [CNT_W-1:0]  pat_q, pat_d;
  logic [SIG_W-1:0]  golden_q, golden_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [SIG_W-1:0]  mix;

  // State and output registers; reset clears any partial signature.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state_q    <= S_IDLE;
      skip_cnt_q <= '0;
      pat_q      <= '0;
      golden_q   <= '0;
      sig_q      <= SEED;
      beats_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      pat_q      <= pat_d;
      golden_q   <= golden_d;
      sig_q      <= sig_d;
      beats_q    <= beats_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  // Next-state logic; idle cycles (resp_valid low) hold everything.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    pat_d      = pat_q;
    golden_d   = golden_q;
    sig_d      = sig_q;
    beats_d    = beats_q;
    done_d     = done_q;
    pass_d     = pass_q;
    mix        = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(resp);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pat_d      = pat_count;
          golden_d   = golden;
          sig_d      = SEED;
          beats_d    = '0;
          skip_cnt_d = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          if (SKIP != 0) begin
            state_d = S_SKIP;
          end else if (pat_count == '0) begin
            // Nothing to compact and nothing to skip: finish immediately.
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (SEED == golden);
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_SKIP: begin
        if (resp_valid) begin
          if (skip_cnt_q == SKW'(SKIP - 1)) begin
            if (pat_q == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              pass_d  = (sig_q == golden_q);
            end else begin
              state_d = S_RUN;
            end
          end else begin
            skip_cnt_d = skip_cnt_q + SKW'(1);
          end
        end
      end
      S_RUN: begin
        if (resp_valid) begin
          sig_d   = mix;
          beats_d = (beats_q == '1) ? beats_q : beats_q + CNT_W'(1);
          if (beats_d == pat_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (mix == golden_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SKIP) || (state_d == S_RUN);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign beats     = beats_q;

endmodule
